// File: rtl/upcounter_pkg.sv
// Shared state encoding and default sizing for the programmable-modulo up counter.
package upcounter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_MAX_VAL = 15;

endpackage

// File: rtl/upcnt_fsm.sv
// Run/pause/done control for the up counter; decodes START/STOP/ONESHOT into
// datapath strobes (increment, clear, terminal pulse, wrap, abort-to-idle).
module upcnt_fsm
  import upcounter_pkg::*;
(
  input  logic   CLK,
  input  logic   RST,
  input  logic   start_i,
  input  logic   stop_i,
  input  logic   en_i,
  input  logic   oneshot_i,
  input  logic   load_i,
  input  logic   at_max_i,
  output logic   inc_o,
  output logic   clr_o,
  output logic   tc_o,
  output logic   wrap_o,
  output logic   abort_o,
  output state_e state_o
);

  state_e state_q, state_d;

  // A load suppresses counting (and so terminal events), but not START/STOP moves,
  // except that a load in DONE keeps the block in DONE.
  always_comb begin
    state_d = state_q;
    inc_o   = 1'b0;
    clr_o   = 1'b0;
    tc_o    = 1'b0;
    wrap_o  = 1'b0;
    abort_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!stop_i && start_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stop_i) begin
          state_d = ST_PAUSE;
        end else if (en_i && !load_i) begin
          if (at_max_i) begin
            tc_o = 1'b1;
            if (oneshot_i) begin
              state_d = ST_DONE;
            end else begin
              clr_o  = 1'b1;
              wrap_o = 1'b1;
            end
          end else begin
            inc_o = 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        if (stop_i) begin
          state_d = ST_IDLE;
          clr_o   = 1'b1;
          abort_o = 1'b1;
        end else if (start_i) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (stop_i || start_i) begin
          clr_o = 1'b1;
          if (!load_i) begin
            state_d = stop_i ? ST_IDLE : ST_RUN;
            abort_o = stop_i;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/upcounter_4bit_ctrl.sv
// Programmable-modulo up counter (0..MAX_VAL) with run/pause/stop control and
// registered terminal-count pulse. Define UPCNT_OVF_FLAG_EN to add the sticky OVF flag.
module upcounter_4bit_ctrl
  import upcounter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MAX_VAL = DEF_MAX_VAL
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             STOP,
  input  logic             EN,
  input  logic             ONESHOT,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] OUT,
  output logic             TC,
  output logic             DONE,
  output logic             BUSY
`ifdef UPCNT_OVF_FLAG_EN
  ,
  output logic             OVF
`endif
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] out_q, out_d;
  logic             tc_q;
  logic             inc, clr, tc_ev, wrap, abort;
  state_e           state;

  upcnt_fsm u_fsm (
    .CLK      (CLK),
    .RST      (RST),
    .start_i  (START),
    .stop_i   (STOP),
    .en_i     (EN),
    .oneshot_i(ONESHOT),
    .load_i   (LOAD),
    .at_max_i (out_q == MAX),
    .inc_o    (inc),
    .clr_o    (clr),
    .tc_o     (tc_ev),
    .wrap_o   (wrap),
    .abort_o  (abort),
    .state_o  (state)
  );

  // Loaded values are clipped so the count can never sit above MAX_VAL.
  always_comb begin
    out_d = out_q;
    if (LOAD)     out_d = (D > MAX) ? MAX : D;
    else if (clr) out_d = '0;
    else if (inc) out_d = out_q + WIDTH'(1);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      out_q <= out_d;
      tc_q  <= tc_ev;
    end
  end

  assign OUT  = out_q;
  assign TC   = tc_q;
  assign BUSY = (state == ST_RUN);
  assign DONE = (state == ST_DONE);

`ifdef UPCNT_OVF_FLAG_EN
  logic ovf_q;
  // Set beats clear when both land on the same edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)       ovf_q <= 1'b0;
    else if (wrap)  ovf_q <= 1'b1;
    else if (abort) ovf_q <= 1'b0;
  end
  assign OVF = ovf_q;
`else
  logic unused_ok;
  assign unused_ok = abort;
`endif

endmodule

// File: tb/tb_upcounter_4bit_ctrl.sv
// Self-checking bench: two instances (MAX_VAL 9 and 5) share stimulus; a table,
// hand sequences and random cycles are checked against a spec-level model.
module tb_upcounter_4bit_ctrl;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  typedef struct { bit st, sp, en, os, ld; int d; } inp_t;
  typedef struct { int mode; int cnt; bit tc; bit ovf; } mdl_t;
  typedef struct { inp_t i; int out; bit tc, busy, done; } vec_t;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START, STOP, EN, ONESHOT, LOAD;
  logic [3:0] D;
  logic [3:0] out9, out5;
  logic       tc9, tc5, done9, done5, busy9, busy5;
  logic       ovf9, ovf5;

  int checks = 0;
  int errors = 0;
  mdl_t m9, m5;

  always #5 CLK = ~CLK;

  upcounter_4bit_ctrl #(.WIDTH(4), .MAX_VAL(9)) dut9 (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .EN(EN), .ONESHOT(ONESHOT),
    .LOAD(LOAD), .D(D), .OUT(out9), .TC(tc9), .DONE(done9), .BUSY(busy9)
`ifdef UPCNT_OVF_FLAG_EN
    , .OVF(ovf9)
`endif
  );

  upcounter_4bit_ctrl #(.WIDTH(4), .MAX_VAL(5)) dut5 (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .EN(EN), .ONESHOT(ONESHOT),
    .LOAD(LOAD), .D(D), .OUT(out5), .TC(tc5), .DONE(done5), .BUSY(busy5)
`ifdef UPCNT_OVF_FLAG_EN
    , .OVF(ovf5)
`endif
  );

`ifndef UPCNT_OVF_FLAG_EN
  assign ovf9 = 1'b0;
  assign ovf5 = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic inp_t mk(bit st, bit sp, bit en, bit os, bit ld, int d);
    inp_t r;
    r.st = st; r.sp = sp; r.en = en; r.os = os; r.ld = ld; r.d = d;
    return r;
  endfunction

  function automatic vec_t mv(inp_t i, int out, bit tc, bit busy, bit done);
    vec_t v;
    v.i = i; v.out = out; v.tc = tc; v.busy = busy; v.done = done;
    return v;
  endfunction

  // Next state of one counter from the written rules: what START/STOP do in each
  // mode, what an enabled count does at/below the top, then LOAD overriding the count.
  function automatic mdl_t mstep(mdl_t m, int mx, inp_t i);
    mdl_t n = m;
    bit wrapped = 0, aborted = 0;
    n.tc = 0;
    if (m.mode == M_IDLE) begin
      if (i.st && !i.sp) n.mode = M_RUN;
    end else if (m.mode == M_RUN) begin
      if (i.sp) n.mode = M_PAUSE;
      else if (i.en && !i.ld) begin
        if (m.cnt < mx) n.cnt = m.cnt + 1;
        else begin
          n.tc = 1;
          if (i.os) n.mode = M_DONE;
          else begin n.cnt = 0; wrapped = 1; end
        end
      end
    end else if (m.mode == M_PAUSE) begin
      if (i.sp) begin n.mode = M_IDLE; n.cnt = 0; aborted = 1; end
      else if (i.st) n.mode = M_RUN;
    end else begin
      if (i.sp || i.st) begin
        n.cnt = 0;
        if (!i.ld) begin
          n.mode = i.sp ? M_IDLE : M_RUN;
          aborted = i.sp;
        end
      end
    end
    if (i.ld) n.cnt = (i.d > mx) ? mx : i.d;
    if (wrapped) n.ovf = 1;
    else if (aborted) n.ovf = 0;
    return n;
  endfunction

  function automatic mdl_t mreset();
    mdl_t r;
    r.mode = M_IDLE; r.cnt = 0; r.tc = 0; r.ovf = 0;
    return r;
  endfunction

  task automatic cmp_models();
    chk("m9 out", out9, m9.cnt);
    chk("m9 tc", tc9, m9.tc);
    chk("m9 busy", busy9, m9.mode == M_RUN);
    chk("m9 done", done9, m9.mode == M_DONE);
    chk("m5 out", out5, m5.cnt);
    chk("m5 tc", tc5, m5.tc);
    chk("m5 busy", busy5, m5.mode == M_RUN);
    chk("m5 done", done5, m5.mode == M_DONE);
`ifdef UPCNT_OVF_FLAG_EN
    chk("m9 ovf", ovf9, m9.ovf);
    chk("m5 ovf", ovf5, m5.ovf);
`endif
  endtask

  // Drive one cycle of inputs, let one rising edge consume them, then compare.
  task automatic cyc(input inp_t i);
    START = i.st; STOP = i.sp; EN = i.en; ONESHOT = i.os; LOAD = i.ld; D = i.d[3:0];
    @(posedge CLK);
    #1;
    m9 = mstep(m9, 9, i);
    m5 = mstep(m5, 5, i);
    cmp_models();
  endtask

  vec_t tbl[$];
  int   tc_cnt;
  inp_t ri;

  initial begin
    RST = 1'b0; START = 0; STOP = 0; EN = 0; ONESHOT = 0; LOAD = 0; D = '0;
    m9 = mreset(); m5 = mreset();
    #3;
    chk("rst out", out9, 0);
    chk("rst tc", tc9, 0);
    chk("rst busy", busy9, 0);
    chk("rst done", done9, 0);
    chk("rst ovf", ovf9, 0);
    @(negedge CLK); RST = 1'b1;

    // Table for the MAX_VAL=9 instance: LOAD clip/priority, EN gating, START+STOP,
    // wrap, one-shot, LOAD in DONE, restart and abort.
    tbl.push_back(mv(mk(0,0,0,0,1,12), 9,0,0,0));
    tbl.push_back(mv(mk(1,0,0,0,1,4),  4,0,1,0));
    tbl.push_back(mv(mk(0,0,1,0,0,0),  5,0,1,0));
    tbl.push_back(mv(mk(0,0,0,0,0,0),  5,0,1,0));
    tbl.push_back(mv(mk(0,0,0,0,0,0),  5,0,1,0));
    tbl.push_back(mv(mk(0,0,0,0,0,0),  5,0,1,0));
    tbl.push_back(mv(mk(1,1,1,0,0,0),  5,0,0,0));
    tbl.push_back(mv(mk(1,0,0,0,0,0),  5,0,1,0));
    tbl.push_back(mv(mk(0,0,1,0,0,0),  6,0,1,0));
    tbl.push_back(mv(mk(0,0,1,0,0,0),  7,0,1,0));
    tbl.push_back(mv(mk(0,0,1,0,0,0),  8,0,1,0));
    tbl.push_back(mv(mk(0,0,1,0,0,0),  9,0,1,0));
    tbl.push_back(mv(mk(0,0,1,0,0,0),  0,1,1,0));
    tbl.push_back(mv(mk(0,0,1,0,0,0),  1,0,1,0));
    tbl.push_back(mv(mk(0,1,1,0,0,0),  1,0,0,0));
    tbl.push_back(mv(mk(0,1,0,0,0,0),  0,0,0,0));
    tbl.push_back(mv(mk(1,0,0,1,0,0),  0,0,1,0));
    tbl.push_back(mv(mk(0,0,1,1,1,8),  8,0,1,0));
    tbl.push_back(mv(mk(0,0,1,1,0,0),  9,0,1,0));
    tbl.push_back(mv(mk(0,0,1,1,0,0),  9,1,0,1));
    tbl.push_back(mv(mk(0,0,0,1,0,0),  9,0,0,1));
    tbl.push_back(mv(mk(0,0,0,1,1,3),  3,0,0,1));
    tbl.push_back(mv(mk(1,0,0,0,0,0),  0,0,1,0));
    tbl.push_back(mv(mk(0,0,1,0,0,0),  1,0,1,0));
    tbl.push_back(mv(mk(0,1,0,0,0,0),  1,0,0,0));
    tbl.push_back(mv(mk(0,1,0,0,0,0),  0,0,0,0));
    foreach (tbl[k]) begin
      cyc(tbl[k].i);
      chk($sformatf("tbl%0d out", k), out9, tbl[k].out);
      chk($sformatf("tbl%0d tc", k), tc9, tbl[k].tc);
      chk($sformatf("tbl%0d busy", k), busy9, tbl[k].busy);
      chk($sformatf("tbl%0d done", k), done9, tbl[k].done);
    end

    // Continuous wrap, MAX_VAL=9: 25 enabled edges hold exactly two TC pulses.
    cyc(mk(0,1,0,0,0,0)); cyc(mk(0,1,0,0,0,0));
    cyc(mk(1,0,0,0,0,0));
    tc_cnt = 0;
    for (int e = 1; e <= 25; e++) begin
      cyc(mk(0,0,1,0,0,0));
      chk("wrap out", out9, e % 10);
      chk("wrap tc", tc9, (e % 10) == 0);
      if (tc9) tc_cnt++;
    end
    chk("wrap tc count", tc_cnt, 2);
`ifdef UPCNT_OVF_FLAG_EN
    chk("ovf set", ovf9, 1);
    cyc(mk(0,1,0,0,0,0)); cyc(mk(0,1,0,0,0,0));
    chk("ovf clr", ovf9, 0);
`endif

    // One-shot on MAX_VAL=5: climbs to 5, holds, single TC, then restart from 0.
    cyc(mk(0,1,0,0,0,0)); cyc(mk(0,1,0,0,0,0));
    cyc(mk(1,0,0,1,0,0));
    tc_cnt = 0;
    for (int e = 1; e <= 8; e++) begin
      cyc(mk(0,0,1,1,0,0));
      chk("os out", out5, (e > 5) ? 5 : e);
      if (tc5) tc_cnt++;
    end
    chk("os tc count", tc_cnt, 1);
    chk("os done", done5, 1);
    chk("os busy", busy5, 0);
    cyc(mk(1,0,0,1,0,0));
    chk("os restart out", out5, 0);
    chk("os restart busy", busy5, 1);

    // Pause at 3, resume to 5, then double STOP aborts to IDLE at 0.
    cyc(mk(0,1,0,0,0,0)); cyc(mk(0,1,0,0,0,0));
    cyc(mk(1,0,0,0,0,0));
    for (int e = 0; e < 3; e++) cyc(mk(0,0,1,0,0,0));
    cyc(mk(0,1,1,0,0,0));
    chk("pause out", out9, 3);
    chk("pause busy", busy9, 0);
    cyc(mk(1,0,0,0,0,0));
    cyc(mk(0,0,1,0,0,0));
    chk("resume out a", out9, 4);
    cyc(mk(0,0,1,0,0,0));
    chk("resume out b", out9, 5);
    cyc(mk(0,1,0,0,0,0));
    cyc(mk(0,1,0,0,0,0));
    chk("abort out", out9, 0);
    chk("abort busy", busy9, 0);

    // Asynchronous reset mid-run at OUT=7, no clock edge needed.
    cyc(mk(1,0,0,0,0,0));
    for (int e = 0; e < 7; e++) cyc(mk(0,0,1,0,0,0));
    chk("pre-rst out", out9, 7);
    RST = 1'b0;
    #1;
    chk("arst out", out9, 0);
    chk("arst tc", tc9, 0);
    chk("arst busy", busy9, 0);
    m9 = mreset(); m5 = mreset();
    @(negedge CLK); RST = 1'b1;
    cyc(mk(1,0,0,0,0,0));
    cyc(mk(0,0,1,0,0,0));
    chk("post-rst out", out9, 1);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      ri = mk($urandom % 4 == 0, $urandom % 8 == 0, $urandom % 4 != 0,
              $urandom % 2 == 1, $urandom % 10 == 0, int'($urandom % 16));
      cyc(ri);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
